// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding, response codes and default bus widths.
// Combinational definitions only; no timing or flow control of its own.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bundle: requester drives select/control/write data, completer returns ready/error/read data.
// No storage; the completer registers every signal it returns.
interface apb_slave_mem_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, asynchronous clear to the power-up image.
// With APB_SLV_RO_REGION_EN the top 8 words reset to an ID block (8'hA0 + index).
module apb_slave_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              presetn,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef APB_SLV_RO_REGION_EN
        mem[i] <= (i >= DEPTH - 8) ? DATA_W'(32'hA0 + 32'(i) - 32'(DEPTH - 8)) : '0;
`else
        mem[i] <= '0;
`endif
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer over a register array; completes WAIT_CYCLES+1 cycles after setup, error decode on range/protocol.
// Optional read-only ID block in the top 8 words when APB_SLV_RO_REGION_EN is defined.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            presetn,
  apb_slave_mem_if.slave  bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
`ifdef APB_SLV_RO_REGION_EN
  localparam logic [ADDR_W:0] RO_BASE = (ADDR_W + 1)'(DEPTH - 8);
`endif

  apb_state_t        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_write;
  logic              cur_err;
  logic [DATA_W-1:0] rd_data;
  logic              we;

  // Zero-wait completion decides in IDLE from the live bus; otherwise the latched copy is used.
  always_comb begin
    cur_addr  = (state == IDLE) ? bus.paddr  : lat_addr;
    cur_write = (state == IDLE) ? bus.pwrite : lat_write;
    cur_err   = ({1'b0, cur_addr} >= DEPTH_A);
`ifdef APB_SLV_RO_REGION_EN
    if (cur_write && ({1'b0, cur_addr} >= RO_BASE)) begin
      cur_err = 1'b1;
    end
`endif
  end

  assign we = (state == RESP) && lat_write && (pslverr_q == APB_OKAY);

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .presetn (presetn),
    .we      (we),
    .waddr   (lat_addr[IDX_W-1:0]),
    .wdata   (lat_wdata),
    .raddr   (cur_addr[IDX_W-1:0]),
    .rdata   (rd_data)
  );

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= APB_OKAY;
    end else begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= APB_OKAY;
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            lat_addr  <= bus.paddr;
            lat_write <= bus.pwrite;
            lat_wdata <= bus.pwdata;
            cnt       <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= cur_err ? APB_ERR : APB_OKAY;
              prdata_q  <= (cur_write || cur_err) ? '0 : rd_data;
            end else begin
              state <= WAIT;
            end
          end else if (bus.psel && bus.penable) begin
            // Access phase with no setup: answer with an error and touch nothing.
            state     <= RESP;
            lat_write <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= APB_ERR;
          end
        end
        WAIT: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.penable) begin
            if (cnt == 4'd1) begin
              state     <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= cur_err ? APB_ERR : APB_OKAY;
              prdata_q  <= (cur_write || cur_err) ? '0 : rd_data;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: three completers (0, 1 and 3 wait states) share one stimulus bus, steered by dsel.
// Expected values are hand-derived; the ID block expectations follow APB_SLV_RO_REGION_EN.
module tb_apb_slave_mem;

  logic       clk     = 1'b0;
  logic       presetn = 1'b0;
  logic       psel    = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite  = 1'b0;
  logic [7:0] paddr   = 8'h00;
  logic [7:0] pwdata  = 8'h00;
  int         dsel    = 1;

  logic [7:0] prdata_m;
  logic       pready_m;
  logic       pslverr_m;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m1 [64];

  always #5 clk = ~clk;

  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  assign bus0.psel = psel && (dsel == 0);
  assign bus1.psel = psel && (dsel == 1);
  assign bus2.psel = psel && (dsel == 2);
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus2.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus2.pwrite = pwrite;
  assign bus0.paddr = paddr;
  assign bus1.paddr = paddr;
  assign bus2.paddr = paddr;
  assign bus0.pwdata = pwdata;
  assign bus1.pwdata = pwdata;
  assign bus2.pwdata = pwdata;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .presetn(presetn), .bus(bus0.slave));
  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .presetn(presetn), .bus(bus1.slave));
  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .presetn(presetn), .bus(bus2.slave));

  always_comb begin
    case (dsel)
      0:       begin prdata_m = bus0.prdata; pready_m = bus0.pready; pslverr_m = bus0.pslverr; end
      1:       begin prdata_m = bus1.prdata; pready_m = bus1.pready; pslverr_m = bus1.pslverr; end
      default: begin prdata_m = bus2.prdata; pready_m = bus2.pready; pslverr_m = bus2.pslverr; end
    endcase
  end

  function automatic logic [7:0] init_val(input int i);
`ifdef APB_SLV_RO_REGION_EN
    return (i >= 56) ? 8'(32'hA0 + 32'(i) - 32'd56) : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Setup, then access with the bus lines scrambled: the completer must work from its latched copy.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic err, output int lat);
    logic done;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; pwrite = ~wr; paddr = ~a; pwdata = ~d;
    lat = 1; done = 1'b0; rd = '0; err = 1'b0;
    while (!done && lat <= 30) begin
      @(negedge clk);
      if (pready_m) begin
        rd = prdata_m; err = pslverr_m; done = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("xfer_done", 32'(done), 32'd1);
  endtask

  task automatic do_wr(input string tag, input logic [7:0] a, input logic [7:0] d,
                       input logic exp_err, input int exp_lat);
    logic [7:0] rd;
    logic       err;
    int         lat;
    xfer(1'b1, a, d, rd, err, lat);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_rd(input string tag, input logic [7:0] a, input logic [7:0] exp_d,
                       input logic exp_err, input int exp_lat);
    logic [7:0] rd;
    logic       err;
    int         lat;
    xfer(1'b0, a, 8'h00, rd, err, lat);
    chk({tag, "_data"}, 32'(rd), 32'(exp_d));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       err;
    int         lat;
    logic       seen;

    for (int i = 0; i < 64; i++) m1[i] = init_val(i);

    // Reset values on every instance
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      dsel = d; #1;
      chk($sformatf("rst_pready_%0d", d), 32'(pready_m), 32'd0);
      chk($sformatf("rst_pslverr_%0d", d), 32'(pslverr_m), 32'd0);
      chk($sformatf("rst_prdata_%0d", d), 32'(prdata_m), 32'd0);
    end
    @(negedge clk); presetn = 1'b1;

    // One wait state: write then read back, out-of-range read and write
    dsel = 1;
    do_wr("w1_wr05", 8'h05, 8'h3C, 1'b0, 2);
    m1[5] = 8'h3C;
    do_rd("w1_rd05", 8'h05, 8'h3C, 1'b0, 2);
    do_rd("w1_rd40", 8'h40, 8'h00, 1'b1, 2);
    do_wr("w1_wr50", 8'h50, 8'hAA, 1'b1, 2);
    idle();

    // Access without setup from IDLE
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h06; pwdata = 8'h99;
    @(negedge clk); @(negedge clk);
    chk("proto_pready", 32'(pready_m), 32'd1);
    chk("proto_pslverr", 32'(pslverr_m), 32'd1);
    chk("proto_prdata", 32'(prdata_m), 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("proto_pready_drop", 32'(pready_m), 32'd0);
    chk("proto_pslverr_drop", 32'(pslverr_m), 32'd0);

`ifdef APB_SLV_RO_REGION_EN
    do_wr("ro_wr3f", 8'h3F, 8'h11, 1'b1, 2);
    do_rd("ro_rd3f", 8'h3F, 8'hA7, 1'b0, 2);
`endif

    for (int i = 0; i < 64; i++) begin
      xfer(1'b0, 8'(i), 8'h00, rd, err, lat);
      chk($sformatf("rb1_%0d", i), 32'(rd), 32'(m1[i]));
    end
    idle();

    // Zero wait states: back-to-back writes then reads
    dsel = 0;
    for (int i = 0; i < 4; i++) do_wr($sformatf("w0_wr%0d", i), 8'(i), 8'(8'h11 * (i + 1)), 1'b0, 1);
    for (int i = 0; i < 4; i++) do_rd($sformatf("w0_rd%0d", i), 8'(i), 8'(8'h11 * (i + 1)), 1'b0, 1);
    idle();

    // Three wait states: normal transfer, then abort in the second WAIT cycle
    dsel = 2;
    do_wr("w3_wr20", 8'h20, 8'h77, 1'b0, 4);
    do_rd("w3_rd20", 8'h20, 8'h77, 1'b0, 4);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready_m) seen = 1'b1;
    end
    chk("abort_no_pready", 32'(seen), 32'd0);
    do_rd("abort_rd10", 8'h10, 8'h00, 1'b0, 4);
    idle();

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    presetn = 1'b0; #1;
    chk("rstwait_pready", 32'(pready_m), 32'd0);
    chk("rstwait_pslverr", 32'(pslverr_m), 32'd0);
    chk("rstwait_prdata", 32'(prdata_m), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); presetn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      xfer(1'b0, 8'(i), 8'h00, rd, err, lat);
      chk($sformatf("rb2_%0d", i), 32'(rd), 32'(init_val(i)));
    end
    idle();

    // Reset while a read response is on the bus must clear outputs without a clock edge
    dsel = 0;
    do_wr("w0_wr07", 8'h07, 8'h5A, 1'b0, 1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h07;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("rstresp_pre_pready", 32'(pready_m), 32'd1);
    chk("rstresp_pre_prdata", 32'(prdata_m), 32'h5A);
    presetn = 1'b0; #1;
    chk("rstresp_pready", 32'(pready_m), 32'd0);
    chk("rstresp_prdata", 32'(prdata_m), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); presetn = 1'b1;
    do_rd("rstresp_rd07", 8'h07, 8'h00, 1'b0, 1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
